// File: rtl/reg_write_scheduler_if.sv
// Writeback request, reservation/query and register-file write bus of the scheduler.
// The requester side (control FSM / datapath / decode) uses master; the scheduler uses slave.
interface reg_write_scheduler_if #(
    parameter int WORD_SIZE = 16,
    parameter int IDX_W     = 2
);
    logic                 a_valid;
    logic                 a_ready;
    logic [IDX_W-1:0]     a_idx;
    logic [WORD_SIZE-1:0] a_data;
    logic                 b_valid;
    logic                 b_ready;
    logic [IDX_W-1:0]     b_idx;
    logic [WORD_SIZE-1:0] b_data;
    logic                 rsv_valid;
    logic                 rsv_ready;
    logic [IDX_W-1:0]     rsv_idx;
    logic [IDX_W-1:0]     q1_idx;
    logic [IDX_W-1:0]     q2_idx;
    logic                 q_stall;
    logic                 rf_writeM;
    logic [IDX_W-1:0]     rf_writeIdx;
    logic [WORD_SIZE-1:0] rf_writeData;
    logic                 underflow_err;

    modport master (
        output a_valid, a_idx, a_data, b_valid, b_idx, b_data,
               rsv_valid, rsv_idx, q1_idx, q2_idx,
        input  a_ready, b_ready, rsv_ready, q_stall,
               rf_writeM, rf_writeIdx, rf_writeData, underflow_err
    );

    modport slave (
        input  a_valid, a_idx, a_data, b_valid, b_idx, b_data,
               rsv_valid, rsv_idx, q1_idx, q2_idx,
        output a_ready, b_ready, rsv_ready, q_stall,
               rf_writeM, rf_writeIdx, rf_writeData, underflow_err
    );
endinterface

// File: rtl/reg_write_scheduler.sv
// Round-robin scheduler for the single register-file write port, with a per-register
// pending-write scoreboard used by decode for hazard stalls.
module pend_cnt #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt
);
    // Simultaneous reserve and retire cancel; decrement saturates at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

module reg_write_scheduler #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_REGS  = 4,
    parameter int IDX_W     = 2,
    parameter int PEND_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    reg_write_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

    typedef struct packed {
        logic [IDX_W-1:0]     idx;
        logic [WORD_SIZE-1:0] data;
    } wreq_t;

    state_t st, nxt;
    logic   rr_b;
    logic   grant_a, grant_b, a_rdy, b_rdy;
    logic   w_m;
    wreq_t  w_req, sel;
    logic   retire, rsv_fire, rsv_rdy, uf, uf_hit;

    logic [NUM_REGS-1:0][PEND_W-1:0] pend;
    logic [NUM_REGS-1:0]             inc, dec;

    // rr_b=1 means B wins the next contended cycle.
    assign grant_a = bus.a_valid && (!bus.b_valid || !rr_b);
    assign grant_b = bus.b_valid && (!bus.a_valid ||  rr_b);
    assign sel     = a_rdy ? wreq_t'{bus.a_idx, bus.a_data} : wreq_t'{bus.b_idx, bus.b_data};

    always_comb begin
        nxt   = st;
        a_rdy = 1'b0;
        b_rdy = 1'b0;
        case (st)
            IDLE: begin
                a_rdy = grant_a;
                b_rdy = grant_b;
                if (grant_a || grant_b) nxt = SETUP;
            end
            SETUP:   nxt = STROBE;
            STROBE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st    <= IDLE;
            rr_b  <= 1'b0;
            w_m   <= 1'b0;
            w_req <= '0;
        end else begin
            st  <= nxt;
            w_m <= (nxt == STROBE);
            if (a_rdy || b_rdy) begin
                w_req <= sel;
                rr_b  <= a_rdy;
            end
        end
    end

    assign retire   = (st == STROBE);
    assign rsv_rdy  = (pend[bus.rsv_idx] != '1);
    assign rsv_fire = bus.rsv_valid && rsv_rdy;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_pend
        assign inc[i] = rsv_fire && (bus.rsv_idx == IDX_W'(i));
        assign dec[i] = retire && (w_req.idx == IDX_W'(i));
        pend_cnt #(.PEND_W(PEND_W)) u_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .inc     (inc[i]),
            .dec     (dec[i]),
            .cnt     (pend[i])
        );
    end

    // A same-edge reservation covers the retiring write, so it is not an underflow.
    assign uf_hit = retire && (pend[w_req.idx] == '0) &&
                    !(rsv_fire && bus.rsv_idx == w_req.idx);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) uf <= 1'b0;
        else if (uf_hit) uf <= 1'b1;
    end

    assign bus.a_ready       = a_rdy;
    assign bus.b_ready       = b_rdy;
    assign bus.rsv_ready     = rsv_rdy;
    assign bus.q_stall       = (pend[bus.q1_idx] != '0) | (pend[bus.q2_idx] != '0);
    assign bus.rf_writeM     = w_m;
    assign bus.rf_writeIdx   = w_req.idx;
    assign bus.rf_writeData  = w_req.data;
    assign bus.underflow_err = uf;
endmodule
